// File: rtl/mire_writer_pkg.sv
// Types and defaults private to the test-pattern writer.
package mire_writer_pkg;

  localparam int BURST_DEFAULT = 64;
  localparam int PAUSE_DEFAULT = 1;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

endpackage

// File: rtl/video_pkg.sv
// Video definitions shared by the test-pattern writer and the display controller:
// frame geometry defaults, colours and the test-pattern pixel function.
package video_pkg;

  localparam int HDISP_DEFAULT = 800;
  localparam int VDISP_DEFAULT = 480;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // White grid line on every 16th column and row, black elsewhere.
  function automatic logic [23:0] mire_rgb(input logic [15:0] x, input logic [15:0] y);
    if (((x & 16'h000F) == 16'h0000) || ((y & 16'h000F) == 16'h0000)) begin
      return WHITE;
    end
    return BLACK;
  endfunction

endpackage

// File: rtl/mire_writer.sv
// Wishbone classic-cycle master that endlessly paints the grid test pattern into
// the framebuffer, releasing cyc after every BURST writes so the display reader gets the bus.
module mire_writer
  import video_pkg::*;
  import mire_writer_pkg::*;
#(
  parameter int HDISP = HDISP_DEFAULT,
  parameter int VDISP = VDISP_DEFAULT,
  parameter int BURST = BURST_DEFAULT,
  parameter int PAUSE = PAUSE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wshb_adr_o,
  output logic [31:0] wshb_dat_ms_o,
  output logic        wshb_we_o,
  output logic [3:0]  wshb_sel_o,
  output logic        wshb_stb_o,
  output logic        wshb_cyc_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic        wshb_ack_i,
  input  logic [31:0] wshb_dat_sm_i,
  output logic [7:0]  frame_cnt_o
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW = (PAUSE > 1) ? $clog2(PAUSE) : 1;

  localparam logic [15:0]   X_LAST = 16'(HDISP - 1);
  localparam logic [15:0]   Y_LAST = 16'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAUSE - 1);

  state_e        state_q, state_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [31:0]   adr_q, adr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [7:0]    frame_q, frame_d;
  logic          cyc_q, cyc_d;

  // Read data is never consumed by a write-only master.
  logic unused_dat_sm;
  assign unused_dat_sm = ^wshb_dat_sm_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_WRITE;
      x_q     <= '0;
      y_q     <= '0;
      adr_q   <= '0;
      burst_q <= '0;
      pause_q <= '0;
      frame_q <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      adr_q   <= adr_d;
      burst_q <= burst_d;
      pause_q <= pause_d;
      frame_q <= frame_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    adr_d   = adr_q;
    burst_d = burst_q;
    pause_d = pause_q;
    frame_d = frame_q;
    cyc_d   = cyc_q;
    case (state_q)
      ST_WRITE: begin
        cyc_d = 1'b1;
        // Gate on cyc_q so an ack seen while cyc is still low after reset is ignored.
        if (cyc_q && wshb_ack_i) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              adr_d   = '0;
              frame_d = frame_q + 8'd1;
            end else begin
              y_d   = y_q + 16'd1;
              adr_d = adr_q + 32'd4;
            end
          end else begin
            x_d   = x_q + 16'd1;
            adr_d = adr_q + 32'd4;
          end
          if (burst_q == B_LAST) begin
            burst_d = '0;
            pause_d = '0;
            state_d = ST_PAUSE;
            cyc_d   = 1'b0;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end
      end
      ST_PAUSE: begin
        cyc_d = 1'b0;
        if (pause_q == P_LAST) begin
          state_d = ST_WRITE;
          cyc_d   = 1'b1;
        end else begin
          pause_d = pause_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_WRITE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign wshb_adr_o    = adr_q;
  assign wshb_dat_ms_o = {8'h00, mire_rgb(x_q, y_q)};
  assign wshb_we_o     = 1'b1;
  assign wshb_sel_o    = 4'b1111;
  assign wshb_stb_o    = cyc_q;
  assign wshb_cyc_o    = cyc_q;
  assign wshb_cti_o    = 3'b000;
  assign wshb_bte_o    = 2'b00;
  assign frame_cnt_o   = frame_q;

endmodule
